// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor, diff = a - b.
// One full-subtractor cell handles a single bit per clock, LSB first, with
// the borrow carried between cycles in a register. The controller sees a
// start/busy/done handshake and may issue a new start in the DONE cycle.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  // One extra counter bit so the count never wraps within an operation.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  // Only WIDTH-1 partial bits need storing; the last bit goes straight to diff.
  logic [WIDTH-2:0] res_sh_reg;
  logic             bw_reg;
  logic [CW-1:0]    cnt_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             borrow_reg;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_reg;
`endif

  logic             a_bit;
  logic             b_bit;
  logic             d_bit;
  logic             bw_next;
  logic [WIDTH-1:0] shifted;
  logic             last_bit;
  logic             accept;

  // Full-subtractor cell on the current LSBs plus handshake decode.
  always_comb begin
    a_bit    = a_sh_reg[0];
    b_bit    = b_sh_reg[0];
    d_bit    = a_bit ^ b_bit ^ bw_reg;
    bw_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bw_reg);
    shifted  = {d_bit, res_sh_reg};
    last_bit = (cnt_reg == CW'(WIDTH - 1));
    accept   = start && ((state_reg == IDLE) || (state_reg == DONE));
  end

  // Control FSM, datapath shift registers and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      res_sh_reg <= '0;
      bw_reg     <= 1'b0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      diff_reg   <= '0;
      borrow_reg <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_reg    <= 1'b0;
`endif
    end else if (accept) begin
      // New operation from IDLE or back-to-back from DONE.
      state_reg  <= RUN;
      a_sh_reg   <= a;
      b_sh_reg   <= b;
      res_sh_reg <= '0;
      bw_reg     <= 1'b0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b1;
      done_reg   <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          a_sh_reg   <= a_sh_reg >> 1;
          b_sh_reg   <= b_sh_reg >> 1;
          res_sh_reg <= shifted[WIDTH-1:1];
          bw_reg     <= bw_next;
          cnt_reg    <= cnt_reg + CW'(1);
          if (last_bit) begin
            // Results are published only here, so no partial value is visible.
            state_reg  <= DONE;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b1;
            diff_reg   <= shifted;
            borrow_reg <= bw_next;
`ifdef SERIAL_SUB_OVF_EN
            // On the last bit the shift registers hold the original MSBs.
            ovf_reg    <= (a_bit ^ b_bit) & (a_bit ^ d_bit);
`endif
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign diff   = diff_reg;
  assign borrow = borrow_reg;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf    = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor (WIDTH=4): directed vectors with
// hand-computed results pushed into a scoreboard queue; an independent
// monitor pops and checks on every done pulse.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  typedef struct packed {
    logic [W-1:0] d;
    logic         bw;
    logic         ov;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   done_count = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitor: one line and one scoreboard pop per done pulse.
  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      exp_t e;
      done_count++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: diff=%0h borrow=%0b with no pending op", diff, borrow);
      end else begin
        e = exp_q.pop_front();
`ifdef SERIAL_SUB_OVF_EN
        if (diff !== e.d || borrow !== e.bw || ovf !== e.ov) begin
          fails++;
          $display("FAIL result %0h-%0h: diff=%0h borrow=%0b ovf=%0b expected diff=%0h borrow=%0b ovf=%0b",
                   e.ea, e.eb, diff, borrow, ovf, e.d, e.bw, e.ov);
        end else begin
          $display("ok   result %0h-%0h: diff=%0h borrow=%0b ovf=%0b", e.ea, e.eb, diff, borrow, ovf);
        end
`else
        if (diff !== e.d || borrow !== e.bw) begin
          fails++;
          $display("FAIL result %0h-%0h: diff=%0h borrow=%0b expected diff=%0h borrow=%0b",
                   e.ea, e.eb, diff, borrow, e.d, e.bw);
        end else begin
          $display("ok   result %0h-%0h: diff=%0h borrow=%0b", e.ea, e.eb, diff, borrow);
        end
`endif
      end
    end
  end

  // Call at a negedge: drive start for one cycle and optionally queue the result.
  task automatic start_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic [W-1:0] ed, input logic ebw, input logic eov,
                          input bit push);
    exp_t e;
    start = 1'b1;
    a     = va;
    b     = vb;
    if (push) begin
      e.d  = ed;
      e.bw = ebw;
      e.ov = eov;
      e.ea = va;
      e.eb = vb;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Advance negedge by negedge until done is seen, bounded.
  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s: no done within 20 cycles", name);
    end
  endtask

  initial begin
    int dc;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", W'(busy), W'(0));
    check("reset_done", W'(done), W'(0));
    check("reset_diff", diff, W'(0));
    check("reset_borrow", W'(borrow), W'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // 8 - 7: busy for 4 cycles, then done with busy low.
    start_op(4'd8, 4'd7, 4'd1, 1'b0, 1'b0, 1);
    for (int k = 0; k < W; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("run%0d_busy", k), W'(busy), W'(1));
      check($sformatf("run%0d_done", k), W'(done), W'(0));
    end
    @(negedge clk);
    check("done_cycle_done", W'(done), W'(1));
    check("done_cycle_busy", W'(busy), W'(0));

    // Back-to-back issue in the DONE cycle: no IDLE gap.
    start_op(4'd11, 4'd5, 4'd6, 1'b0, 1'b0, 1);
    check("b2b_busy", W'(busy), W'(1));
    wait_done("wait_11_5");
    start_op(4'd5, 4'd11, 4'hA, 1'b1, 1'b0, 1);
    wait_done("wait_5_11");
    @(negedge clk);
    start_op(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1);
    wait_done("wait_0_0");

    // start during RUN is ignored: exactly one done for 9 - 2.
    @(negedge clk);
    dc = done_count;
    start_op(4'd9, 4'd2, 4'd7, 1'b0, 1'b0, 1);
    @(negedge clk);
    start_op(4'd3, 4'd1, 4'd0, 1'b0, 1'b0, 0);
    repeat (8) @(negedge clk);
    check("ignored_start_dones", W'(done_count - dc), W'(1));
    check("ignored_start_diff", diff, W'(7));

    // Reset in the 2nd RUN cycle aborts with no done.
    dc = done_count;
    start_op(4'd6, 4'd1, 4'd0, 1'b0, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_diff", diff, W'(0));
    check("abort_busy", W'(busy), W'(0));
    check("abort_done", W'(done), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_no_done", W'(done_count - dc), W'(0));

    start_op(4'd15, 4'd15, 4'd0, 1'b0, 1'b0, 1);
    wait_done("wait_15_15");

`ifdef SERIAL_SUB_OVF_EN
    @(negedge clk);
    start_op(4'd8, 4'd1, 4'd7, 1'b0, 1'b1, 1);
    wait_done("wait_8_1");
    @(negedge clk);
    start_op(4'd7, 4'd1, 4'd6, 1'b0, 1'b0, 1);
    wait_done("wait_7_1");
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_empty", W'(exp_q.size()), W'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial WIDTH-bit subtractor computing diff = a - b, one bit per clock through a single full-subtractor cell with a registered borrow. It is the companion to the combinational ripple-carry adder and trades latency for area. It sits beside the adder in the arithmetic library and uses a start/busy/done handshake so a controller can issue back-to-back operations.

## Interface
- WIDTH, 4, operand and result width in bits (≥ 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when not busy
- a  input  WIDTH  minuend, latched on accepted start
- b  input  WIDTH  subtrahend, latched on accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when result is valid
- diff  output  WIDTH  a - b modulo 2^WIDTH, held until next accepted start completes
- borrow  output  1  final borrow out (1 when a < b unsigned)
- ovf  output  1  signed overflow flag; present only with SERIAL_SUB_OVF_EN

## Operation
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. If start=1 → latch a, b into shift registers, clear internal borrow, bit counter=0 → RUN.
- RUN: each cycle process bit i (LSB first): d = a_i ^ b_i ^ bw; bw' = (~a_i & b_i) | (~(a_i ^ b_i) & bw). Shift d into the result register from the MSB side; shift operands right; increment counter. After the bit WIDTH-1 cycle → DONE.
- DONE: done=1 for exactly one cycle. diff, borrow, and ovf are updated on entry to DONE and then held. If start=1 in DONE, the new operands are accepted and the state goes to RUN (back-to-back). Otherwise → IDLE.
- start while in RUN is ignored. Operands are not re-sampled.
- diff, borrow, and ovf change only on entry to DONE and never show partial results.
- Counter width is clog2(WIDTH)+1 and never wraps within an operation.

## Timing
- Reset (async assert, sync to clk on release): state=IDLE; busy=0, done=0, diff=0, borrow=0, ovf=0; internal borrow, counter, and shift registers are 0.
- Reset asserted mid-operation aborts immediately. No done pulse is produced. Outputs are 0.
- Accepting start at rising edge 0: busy=1 during cycles after edges 0..WIDTH-1. The state is DONE after edge WIDTH, so done=1 and busy=0 in that cycle.
- Latency from start edge to done: WIDTH+1 edges counted inclusively, so done is visible after edge WIDTH.
- Throughput: one result per WIDTH+1 cycles with back-to-back start.

## Configuration
- SERIAL_SUB_OVF_EN defined: ovf port exists. ovf = (a_msb ^ b_msb) & (a_msb ^ diff_msb), evaluated on the latched operands and registered with diff.
- SERIAL_SUB_OVF_EN undefined: ovf port and its logic are absent. All other behaviour is identical.

## Test plan
- WIDTH=4, a=8, b=7, start 1 cycle → done pulse after 4 busy cycles. diff=1, borrow=0.
- a=11, b=5 issued via start during the DONE cycle of the previous op → no IDLE gap. diff=6, borrow=0.
- a=5, b=11 → diff=4'hA, borrow=1. a=0, b=0 → diff=0, borrow=0.
- Pulse start with a=3, b=1 during RUN of op a=9, b=2 → result diff=7, borrow=0. Exactly one done pulse occurs.
- Assert rst_n=0 in the 2nd RUN cycle → all outputs 0 immediately, no done pulse. A new op after release (a=15, b=15) gives diff=0.
- With SERIAL_SUB_OVF_EN: a=8 (-8), b=1 → diff=7, borrow=0, ovf=1. a=7, b=1 → diff=6, ovf=0.
